// File: rtl/mux_rr_sched.sv
// Round-robin scheduler for a shared 16:1 single-bit mux: arbitrates req, drives the select,
// bounds grant tenure with a hold counter and returns a registered sample of the selected line.
module mux_rr_sched #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic [15:0] mux_inp,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        gnt_vld,
  output logic        mux_out,
  output logic        out_vld
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e      state_q;
  logic [3:0]  sel_q, ptr_q;
  logic [15:0] gnt_q;
  logic        gnt_vld_q, mux_out_q, out_vld_q;
  logic [7:0]  hcnt_q;

  logic [3:0]  base, idx, win;
  logic        found, rel, do_grant;

  // Scanning from sel+1 on release puts the current grantee last in line.
  always_comb begin
    base  = (state_q == StGrant) ? sel_q + 4'd1 : ptr_q;
    found = 1'b0;
    win   = 4'd0;
    idx   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      idx = base + 4'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    rel      = !req[sel_q] || (hcnt_q == 8'(MAX_HOLD));
    do_grant = found && ((state_q == StIdle) || rel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= 4'd0;
      gnt_q     <= 16'h0;
      gnt_vld_q <= 1'b0;
      mux_out_q <= 1'b0;
      out_vld_q <= 1'b0;
      ptr_q     <= 4'd0;
      hcnt_q    <= 8'd0;
    end else begin
      mux_out_q <= gnt_vld_q & mux_inp[sel_q];
      out_vld_q <= gnt_vld_q;
      if (do_grant) begin
        state_q   <= StGrant;
        sel_q     <= win;
        gnt_q     <= 16'h1 << win;
        gnt_vld_q <= 1'b1;
        hcnt_q    <= 8'd1;
        ptr_q     <= win + 4'd1;
      end else if (state_q == StGrant) begin
        if (rel) begin
          // sel keeps the last grantee while idle.
          state_q   <= StIdle;
          gnt_q     <= 16'h0;
          gnt_vld_q <= 1'b0;
        end else begin
          hcnt_q <= hcnt_q + 8'd1;
        end
      end
    end
  end

  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign mux_out = mux_out_q;
  assign out_vld = out_vld_q;

endmodule

// File: doc/mux_rr_sched.md
# mux_rr_sched

Round-robin scheduler that shares one 16-to-1 single-bit multiplexer between 16 requesters. It arbitrates a 16-bit request vector, drives the mux select, and holds each grant until the requester releases or a hold limit expires. It also returns a registered sample of the selected input. It sits directly in front of the CLB 16:1 mux datapath and is the only driver of its select lines.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may be held. Legal range 1..255; hold counter is 8 bits.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 16: request vector; bit i is requester i.
- `mux_inp` input 16: data lines feeding the shared mux; bit i belongs to requester i.
- `sel` output 4: mux select, registered; index of the current or last grantee.
- `gnt` output 16: one-hot grant, registered; all zero when no grant.
- `gnt_vld` output 1: a grant is active this cycle.
- `mux_out` output 1: registered sample of `mux_inp[sel]`.
- `out_vld` output 1: `mux_out` holds a sample taken under a valid grant.

## Operation
- **State machine**: two states, IDLE and GRANT.
- **Reset state**: IDLE, `sel`=0, `gnt`=0, `gnt_vld`=0, `mux_out`=0, `out_vld`=0. The internal pointer `ptr`=0 and hold counter `hcnt`=0.
- **Winner search**: first set bit of `req`, scanning `ptr`, `ptr`+1, … with modulo-16 wrap (15 wraps to 0).
- **IDLE**:
  - If `req`=0, stay in IDLE.
  - Otherwise, grant the winner: `sel` = winner index, `gnt` = one-hot of winner, `gnt_vld`=1, `hcnt`=1, go to GRANT.
- **GRANT, release condition**: `req[sel]`=0, or `hcnt`=`MAX_HOLD`.
- **GRANT, no release**: hold the grant; `hcnt` increments.
- **GRANT, release**:
  - Search again with `ptr`=`sel`+1 (mod 16).
  - The current grantee is scanned last, so it is re-granted only when no other requester is pending and its `req` is still high. This happens only on hold-limit expiry.
  - If a winner exists, hand off with zero bubble: the new `sel`/`gnt` take effect at the next edge, and `hcnt`=1.
  - If no winner exists, go to IDLE: `gnt`=0, `gnt_vld`=0, and `sel` keeps its last value.
- **Pointer**: `ptr` updates to (granted index + 1) mod 16 on every new grant, so fairness carries across IDLE periods.
- **Sample path**:
  - Each edge, `mux_out` <= `mux_inp[sel]` and `out_vld` <= `gnt_vld`, both sampled from the registered values before the edge.
  - When `gnt_vld` was 0, `mux_out` <= 0.
- **Fixed behaviours**:
  - `req` bits are not required to be stable.
  - A requester that drops `req` loses its grant after exactly one more granted cycle.
  - Reset takes effect immediately at any time, including mid-grant: all outputs go to reset values asynchronously.
  - After `rst` deasserts, the first grant starts searching from index 0.

## Timing
- Request to grant: `req` sampled at edge N gives `gnt`/`gnt_vld`/`sel` valid after edge N (1-cycle latency).
- Grant to data: `mux_out`/`out_vld` lag `gnt_vld` by exactly 1 cycle.
- Release: `req[sel]` low at edge N ends the grant after edge N; a new grantee, if any, is valid after that same edge.
- Hold limit: a continuously requesting grantee owns the mux for exactly `MAX_HOLD` cycles, then rotates if another requester is pending.
- With `MAX_HOLD`=1, every granted cycle triggers re-arbitration.
- Invariants checked every cycle:
  - `gnt` is one-hot or zero.
  - `gnt_vld` equals the OR of `gnt`.
  - When `gnt_vld`=1, `gnt[sel]`=1.

## Test plan
- **Reset**: assert `rst` mid-grant (requester 5 granted) → all outputs 0 asynchronously, with no clock edge needed. Release `rst` with `req`=16'h0021 → requester 0 granted first, `sel`=0.
- **Single requester**: `req`=16'h0008 held 3 cycles, `mux_inp[3]` toggling 1,0,1 → `sel`=3 and `gnt`=16'h0008 one cycle after request. `mux_out` follows 1,0,1 one cycle later with `out_vld`=1. Drop `req` → `gnt_vld` falls after the next edge and the block returns to IDLE.
- **Hold-limit rotation**: `MAX_HOLD`=4, `req`=16'h0006 held high → grant sequence is 1 for 4 cycles, then 2 for 4 cycles, then 1 again. There are no idle cycles between grants.
- **Wrap-around**: requester 15 granted, `req`=16'h8001, requester 15 drops → next grant goes to 0. With both held high, they alternate 15, 0, 15.
- **All requesters**: `req`=16'hFFFF with `MAX_HOLD`=1 → `sel` steps 0,1,…,15,0 one per cycle. `gnt` is one-hot every cycle.
- **Self re-grant**: only requester 7 requests, held past `MAX_HOLD`=2 → `gnt` stays 16'h0080 continuously and `hcnt` restarts at 1 every 2 cycles. No IDLE state is entered.
